arbiter_n: RTL and testbench

ARBITER_N -- requirements
Module: arbiter_n

---
 rtl/arbiter_n_if.sv | 15 +
 rtl/arbiter_n.sv | 80 ++++++++
 tb/tb_arbiter_n.sv | 215 +++++++++++++++++++++
 3 files changed

// File: rtl/arbiter_n_if.sv
// arbiter_n_if: request/grant bundle between the requesters and arbiter_n
interface arbiter_n_if #(
    parameter int NREQ = 4,
    parameter int SELW = 4
);
    logic [NREQ-1:0] req;
    logic            finish;
    logic [NREQ-1:0] gnt;
    logic [SELW-1:0] sel;
    logic            busy;
    logic            tmo_err;
    logic [SELW-1:0] tmo_id;
    modport master (output req, finish, input gnt, sel, busy, tmo_err, tmo_id);
    modport slave  (input req, finish, output gnt, sel, busy, tmo_err, tmo_id);
endinterface

// File: rtl/arbiter_n.sv
// arbiter_n: N-way bus arbiter, round-robin or fixed priority, with optional grant timeout
module arbiter_n #(
    parameter int NREQ    = 4,
    parameter int SELW    = 4,
    parameter int RR_MODE = 1,
    parameter int TMO_CYC = 0
) (
    input logic       clk,
    input logic       rst,
    arbiter_n_if.slave arb_if
);
    typedef enum logic {IDLE, GRANT} state_e;
    localparam logic [SELW-1:0] LAST_RST = SELW'(NREQ - 1);
    localparam logic [15:0]     TMO_LAST = 16'(TMO_CYC - 1);
    state_e          state_q, state_d;
    logic [NREQ-1:0] gnt_q, gnt_d, rot;
    logic [SELW-1:0] sel_q, sel_d, last_q, last_d, tmo_id_q, tmo_id_d, win;
    logic [SELW:0]   start, off;
    logic [15:0]     cnt_q, cnt_d;
    logic            tmo_err_q, tmo_err_d, tmo_hit;
    // Rotate req so the search always begins at bit 0, then map the offset back.
    always_comb begin
        start = RR_MODE != 0 ? (SELW+1)'(({1'b0, last_q} + 1'b1) % NREQ) : '0;
        rot   = (arb_if.req >> start) | (arb_if.req << (NREQ - int'(start)));
        off   = '0;
        for (int k = NREQ - 1; k >= 0; k--)
            if (rot[k]) off = (SELW+1)'(k);
        win = SELW'((start + off) % NREQ);
    end
    assign tmo_hit = TMO_CYC != 0 && cnt_q == TMO_LAST && !arb_if.finish;
    always_comb begin
        state_d   = state_q;
        gnt_d     = gnt_q;
        sel_d     = sel_q;
        last_d    = last_q;
        cnt_d     = cnt_q;
        tmo_err_d = 1'b0;
        tmo_id_d  = tmo_id_q;
        if (state_q == IDLE) begin
            if (|arb_if.req) begin
                state_d = GRANT;
                gnt_d   = NREQ'(1) << win;
                sel_d   = win;
                cnt_d   = '0;
            end
        end else if (arb_if.finish || tmo_hit) begin
            state_d   = IDLE;
            gnt_d     = '0;
            last_d    = sel_q;
            tmo_err_d = tmo_hit;
            tmo_id_d  = tmo_hit ? sel_q : tmo_id_q;
        end else begin
            cnt_d = TMO_CYC != 0 ? cnt_q + 1'b1 : cnt_q;
        end
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            gnt_q     <= '0;
            sel_q     <= '0;
            last_q    <= LAST_RST;
            cnt_q     <= '0;
            tmo_err_q <= 1'b0;
            tmo_id_q  <= '0;
        end else begin
            state_q   <= state_d;
            gnt_q     <= gnt_d;
            sel_q     <= sel_d;
            last_q    <= last_d;
            cnt_q     <= cnt_d;
            tmo_err_q <= tmo_err_d;
            tmo_id_q  <= tmo_id_d;
        end
    end
    assign arb_if.gnt     = gnt_q;
    assign arb_if.sel     = sel_q;
    assign arb_if.busy    = state_q == GRANT;
    assign arb_if.tmo_err = tmo_err_q;
    assign arb_if.tmo_id  = tmo_id_q;
endmodule

// File: tb/tb_arbiter_n.sv
// tb_arbiter_n: scoreboard bench for a round-robin/timeout arbiter and a fixed-priority one
module tb_arbiter_n;
    localparam int N = 4;
    localparam int RR_OF[2]  = '{1, 0};
    localparam int TMO_OF[2] = '{8, 0};
    logic clk = 1'b0;
    logic rst;
    logic [3:0] req = '0;
    logic finish = 1'b0;
    always #5 clk = ~clk;
    arbiter_n_if #(.NREQ(4), .SELW(2)) if0 ();
    arbiter_n_if #(.NREQ(4), .SELW(2)) if1 ();
    assign if0.req = req;
    assign if0.finish = finish;
    assign if1.req = req;
    assign if1.finish = finish;
    arbiter_n #(.NREQ(4), .SELW(2), .RR_MODE(1), .TMO_CYC(8)) dut0 (.clk(clk), .rst(rst), .arb_if(if0));
    arbiter_n #(.NREQ(4), .SELW(2), .RR_MODE(0), .TMO_CYC(0)) dut1 (.clk(clk), .rst(rst), .arb_if(if1));
    int total = 0, passed = 0;
    bit m_busy[2], m_tmo[2], pb[2];
    int m_cur[2], m_last[2], m_held[2], ecur[2];
    int qs0[$], qs1[$], qt0[$], qt1[$];
    task automatic chk(string name, int act, int exp);
        total++;
        if (act == exp) passed++;
        else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    endtask
    task automatic model_reset();
        for (int d = 0; d < 2; d++) begin
            m_busy[d] = 0; m_tmo[d] = 0; pb[d] = 0;
            m_last[d] = N - 1; m_held[d] = 0; m_cur[d] = 0;
        end
        qs0.delete(); qs1.delete(); qt0.delete(); qt1.delete();
    endtask
    function automatic int pick(int d);
        for (int i = 1; i <= N; i++) begin
            int idx = RR_OF[d] != 0 ? (m_last[d] + i) % N : i - 1;
            if (((req >> idx) & 1) != 0) return idx;
        end
        return -1;
    endfunction
    // Reference behaviour: one idle cycle between holders, finish beats timeout.
    task automatic model_step(int d);
        m_tmo[d] = 0;
        if (m_busy[d]) begin
            if (finish) begin
                m_busy[d] = 0; m_last[d] = m_cur[d];
            end else if (TMO_OF[d] > 0 && m_held[d] == TMO_OF[d] - 1) begin
                m_busy[d] = 0; m_last[d] = m_cur[d]; m_tmo[d] = 1;
                if (d == 0) qt0.push_back(m_cur[d]); else qt1.push_back(m_cur[d]);
            end else m_held[d]++;
        end else if (req != 0) begin
            m_cur[d] = pick(d); m_busy[d] = 1; m_held[d] = 0;
            if (d == 0) qs0.push_back(m_cur[d]); else qs1.push_back(m_cur[d]);
        end
    endtask
    always @(posedge clk or posedge rst)
        if (rst) model_reset();
        else begin
            model_step(0);
            model_step(1);
        end
    task automatic mon(int d, logic [3:0] g, logic [1:0] s, logic b, logic te, logic [1:0] ti);
        string t = d == 0 ? "rr" : "fx";
        int e;
        chk({t, "_busy"}, int'(b), int'(m_busy[d]));
        chk({t, "_tmo_err"}, int'(te), int'(m_tmo[d]));
        if (b && !pb[d]) begin
            e = -1;
            if (d == 0 && qs0.size() > 0) e = qs0.pop_front();
            if (d == 1 && qs1.size() > 0) e = qs1.pop_front();
            chk({t, "_sel"}, int'(s), e);
            ecur[d] = e;
        end
        chk({t, "_gnt"}, int'(g), b ? (1 << ecur[d]) : 0);
        if (te) begin
            e = -1;
            if (d == 0 && qt0.size() > 0) e = qt0.pop_front();
            if (d == 1 && qt1.size() > 0) e = qt1.pop_front();
            chk({t, "_tmo_id"}, int'(ti), e);
        end
        pb[d] = b;
    endtask
    always @(negedge clk)
        if (!rst) begin
            mon(0, if0.gnt, if0.sel, if0.busy, if0.tmo_err, if0.tmo_id);
            mon(1, if1.gnt, if1.sel, if1.busy, if1.tmo_err, if1.tmo_id);
        end
    task automatic wait_busy(int d, string name);
        int n = 0;
        while (!(d == 0 ? if0.busy : if1.busy) && n < 30) begin
            @(negedge clk);
            n++;
        end
        chk({name, "_busy_seen"}, int'(d == 0 ? if0.busy : if1.busy), 1);
    endtask
    task automatic fin();
        finish = 1'b1;
        @(negedge clk);
        finish = 1'b0;
    endtask
    initial begin
        int ord[5], ng, nt, tid, hi3;
        model_reset();
        rst = 1'b0;
        #1 rst = 1'b1;
        #2;
        chk("rst_gnt", int'(if0.gnt), 0);
        chk("rst_sel", int'(if0.sel), 0);
        chk("rst_busy", int'(if0.busy), 0);
        chk("rst_tmo_err", int'(if0.tmo_err), 0);
        chk("rst_tmo_id", int'(if0.tmo_id), 0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        // Round-robin rotation with all requesters active.
        req = 4'b1111;
        for (int j = 0; j < 5; j++) begin
            wait_busy(0, "a_grant");
            ord[j] = int'(if0.sel);
            repeat (2) @(negedge clk);
            fin();
        end
        for (int j = 0; j < 5; j++) chk("a_order", ord[j], j % 4);
        req = '0;
        repeat (2) @(negedge clk);
        // Never finish: grant revoked after 8 cycles.
        req = 4'b0100;
        ng = 0; nt = 0; tid = -1;
        for (int k = 0; k < 11; k++) begin
            @(negedge clk);
            if (k == 0) req = '0;
            if (if0.gnt == 4'b0100) ng++;
            if (if0.tmo_err) begin nt++; tid = int'(if0.tmo_id); end
        end
        chk("b_gnt_cycles", ng, 8);
        chk("b_tmo_pulses", nt, 1);
        chk("b_tmo_id", tid, 2);
        fin();
        @(negedge clk);
        // Finish in the cycle the timeout would fire.
        req = 4'b0100;
        for (int k = 1; k <= 8; k++) begin
            @(negedge clk);
            if (k == 1) req = '0;
            if (k == 8) finish = 1'b1;
        end
        @(negedge clk);
        finish = 1'b0;
        chk("c_busy", int'(if0.busy), 0);
        chk("c_tmo_err", int'(if0.tmo_err), 0);
        @(negedge clk);
        chk("c_tmo_err2", int'(if0.tmo_err), 0);
        // Holder drops req; grant persists until finish.
        req = 4'b0010;
        wait_busy(0, "d_grant");
        chk("d_sel1", int'(if0.sel), 1);
        req = 4'b1101;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            chk("d_hold", int'(if0.gnt), 2);
        end
        fin();
        wait_busy(0, "d_next");
        chk("d_sel2", int'(if0.sel), 2);
        fin();
        req = '0;
        repeat (2) @(negedge clk);
        // Asynchronous reset in the middle of a grant.
        req = 4'b1000;
        wait_busy(0, "e_grant");
        chk("e_sel3", int'(if0.sel), 3);
        #2 rst = 1'b1;
        #1;
        chk("e_async_gnt", int'(if0.gnt), 0);
        chk("e_async_busy", int'(if0.busy), 0);
        chk("e_async_tmo", int'(if0.tmo_err), 0);
        #1 rst = 1'b0;
        req = 4'b1111;
        @(negedge clk);
        chk("e_first_busy", int'(if0.busy), 1);
        chk("e_first_sel", int'(if0.sel), 0);
        fin();
        req = '0;
        repeat (2) @(negedge clk);
        // Fixed priority starves requester 3.
        req = 4'b1010;
        hi3 = 0;
        for (int j = 0; j < 4; j++) begin
            wait_busy(1, "g_grant");
            chk("g_fixed_sel", int'(if1.sel), 1);
            if (if1.gnt[3]) hi3++;
            fin();
        end
        chk("g_starved3", hi3, 0);
        req = '0;
        fin();
        @(negedge clk);
        for (int k = 0; k < 600; k++) begin
            @(negedge clk);
            req = 4'($urandom_range(0, 15));
            finish = $urandom_range(0, 7) == 0;
        end
        req = '0;
        finish = 1'b0;
        repeat (12) @(negedge clk);
        fin();
        repeat (2) @(negedge clk);
        chk("q_sel0_empty", qs0.size(), 0);
        chk("q_sel1_empty", qs1.size(), 0);
        chk("q_tmo0_empty", qt0.size(), 0);
        chk("q_tmo1_empty", qt1.size(), 0);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
